// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong match controller: FSM state encoding,
// serve-direction and winner codes, and the default winning score.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int unsigned DEFAULT_WIN_SCORE = 11;

endpackage

// File: rtl/pong_game_ctrl_rise_detect.sv
// Rising-edge detector: one sample register plus AND-NOT, with the
// resulting pulse registered so it lags the input rise by one cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sig_q, sig_d;
  logic rise_q, rise_d;

  // Next-state: remember the input, flag a 0->1 transition.
  always_comb begin
    sig_d  = sig_in;
    rise_d = sig_in & ~sig_q;
  end

  // Sample register and registered pulse output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: game FSM, scores, serve direction and frame-counted
// delays between points. Optional macro PONG_AUTO_SERVE_EN: when defined the
// ball launches as soon as the serve delay expires; otherwise a start press
// after the delay is also required.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               frame_tick,
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic start_rise;

  rise_detect u_vsync_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_in (vsync),
    .rise   (frame_tick)
  );

  rise_detect u_start_rise (
    .clk    (clk),
    .reset  (reset),
    .sig_in (start),
    .rise   (start_rise)
  );

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic               dir_q, dir_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               run_q, run_d;
  logic               center_q, center_d;
  logic [TIMER_W-1:0] timer_nxt;
  logic               expired;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  // FSM next-state, score/winner/direction updates and Moore output decode.
  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    dir_d    = dir_q;

    // Expiry looks at the post-decrement value so a timed state exits on the
    // edge that consumes its Nth frame_tick (and immediately when N = 0).
    timer_nxt = (frame_tick && (timer_q != '0)) ? timer_q - TIMER_W'(1) : timer_q;
    expired   = (timer_nxt == '0);
    timer_d   = timer_nxt;

    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = WINNER_NONE;
          dir_d    = DIR_RIGHT;
          timer_d  = SERVE_LOAD;
          state_d  = SERVE;
        end
      end
      SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
        if (expired) state_d = PLAY;
`else
        if (expired && start_rise) state_d = PLAY;
`endif
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          timer_d = POINT_LOAD;
          state_d = POINT;
        end else if (miss_left) begin
          score2_d = sat_inc(score2_q);
          dir_d    = DIR_LEFT;
          timer_d  = POINT_LOAD;
          state_d  = POINT;
        end else if (miss_right) begin
          score1_d = sat_inc(score1_q);
          dir_d    = DIR_RIGHT;
          timer_d  = POINT_LOAD;
          state_d  = POINT;
        end
      end
      POINT: begin
        if (expired) begin
          if (score1_q == WIN_VAL) begin
            winner_d = WINNER_P1;
            state_d  = OVER;
          end else if (score2_q == WIN_VAL) begin
            winner_d = WINNER_P2;
            state_d  = OVER;
          end else begin
            timer_d = SERVE_LOAD;
            state_d = SERVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    run_d    = (state_d == PLAY);
    center_d = (state_d == IDLE) || (state_d == SERVE) || (state_d == OVER);
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= WINNER_NONE;
      dir_q    <= DIR_RIGHT;
      timer_q  <= '0;
      run_q    <= 1'b0;
      center_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      run_q    <= run_d;
      center_q <= center_d;
    end
  end

  assign ball_run    = run_q;
  assign ball_center = center_q;
  assign serve_dir   = dir_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl (WIN_SCORE=2, SERVE_FRAMES=2,
// POINT_FRAMES=1). Stimulus pushes cycle-stamped expected snapshots; the
// monitor compares them on the falling edge of the stamped cycle.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset, vsync, start, miss_left, miss_right;
  logic       frame_tick, ball_run, ball_center, serve_dir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] dut_state;

  pong_game_ctrl #(
    .WIN_SCORE    (2),
    .SCORE_W      (4),
    .SERVE_FRAMES (2),
    .POINT_FRAMES (1),
    .TIMER_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .start       (start),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .frame_tick  (frame_tick),
    .ball_run    (ball_run),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .score1      (score1),
    .score2      (score2),
    .winner      (winner),
    .state       (dut_state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    string       name;
    logic [2:0]  st;
    logic [3:0]  s1, s2;
    logic [1:0]  win;
    logic        run, ctr, dir;
    bit          chk_ft;
    logic        ft;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [2:0] e_st  = IDLE;
  logic [3:0] e_s1  = 4'd0;
  logic [3:0] e_s2  = 4'd0;
  logic [1:0] e_win = WINNER_NONE;
  logic       e_dir = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int unsigned dc,
                      input bit chk_ft = 1'b0, input logic ft = 1'b0);
    exp_t e;
    e.at     = cyc + dc;
    e.name   = name;
    e.st     = e_st;
    e.s1     = e_s1;
    e.s2     = e_s2;
    e.win    = e_win;
    e.dir    = e_dir;
    e.run    = (e_st == PLAY);
    e.ctr    = (e_st == IDLE) || (e_st == SERVE) || (e_st == OVER);
    e.chk_ft = chk_ft;
    e.ft     = ft;
    q.push_back(e);
  endtask

  // Monitor: pop every expectation stamped for this cycle and compare.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].at <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.at < cyc) begin
        $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d",
                 m_e.name, m_e.at, cyc);
      end else if (dut_state !== m_e.st || score1 !== m_e.s1 || score2 !== m_e.s2 ||
                   winner !== m_e.win || ball_run !== m_e.run ||
                   ball_center !== m_e.ctr || serve_dir !== m_e.dir ||
                   (m_e.chk_ft && frame_tick !== m_e.ft)) begin
        $display("FAIL %s @%0d: got st=%0d s1=%0d s2=%0d win=%b run=%b ctr=%b dir=%b ft=%b; want st=%0d s1=%0d s2=%0d win=%b run=%b ctr=%b dir=%b ft=%b(chk=%0d)",
                 m_e.name, cyc, dut_state, score1, score2, winner, ball_run,
                 ball_center, serve_dir, frame_tick, m_e.st, m_e.s1, m_e.s2,
                 m_e.win, m_e.run, m_e.ctr, m_e.dir, m_e.ft, m_e.chk_ft);
      end else begin
        n_pass++;
      end
    end
  end

  // From SERVE (timer freshly loaded) to PLAY, probing ignored events on the way.
  task automatic go_play(input string tag);
    vsync = 1'b1;
    push({tag, "_ft_lo"}, 0, 1'b1, 1'b0);
    push({tag, "_ft_hi"}, 1, 1'b1, 1'b1);
    tick(); vsync = 1'b0; tick();
    miss_right = 1'b1; tick(); miss_right = 1'b0;
    push({tag, "_serve_miss"}, 1);
    tick();
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    push({tag, "_serve_start"}, 0);
    vsync = 1'b1; tick(); vsync = 1'b0;
    push({tag, "_serve_last"}, 0);
`ifdef PONG_AUTO_SERVE_EN
    e_st = PLAY;
    push({tag, "_auto_play"}, 1);
    tick(); tick();
`else
    push({tag, "_serve_hold"}, 1);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      vsync = 1'b1; tick(); vsync = 1'b0; tick();
    end
    push({tag, "_serve_10f"}, 0);
    start = 1'b1; tick(); start = 1'b0;
    push({tag, "_start_rise"}, 0);
    e_st = PLAY;
    push({tag, "_manual_play"}, 1);
    tick(); tick();
`endif
  endtask

  // Miss pulse for one cycle; caller has set the expected POINT snapshot.
  task automatic miss(input string tag, input logic l, input logic r);
    miss_left = l; miss_right = r;
    tick();
    miss_left = 1'b0; miss_right = 1'b0;
    push(tag, 0);
    tick();
  endtask

  // One frame in POINT; expect the exit on the cycle after the frame_tick.
  task automatic point_expire(input string tag, input logic [2:0] nxt,
                              input logic [1:0] nwin);
    vsync = 1'b1; tick(); vsync = 1'b0;
    push({tag, "_point_hold"}, 0);
    e_st  = nxt;
    e_win = nwin;
    push({tag, "_after_point"}, 1);
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push("reset", 0, 1'b1, 1'b0);
    push("idle", 2);
    tick(); tick(); tick();

    start = 1'b1; tick(); start = 1'b0;
    push("idle_start_rise", 0);
    e_st = SERVE;
    push("serve_entry", 1);
    tick(); tick();
    go_play("g1");

    e_st = POINT; e_s1 = 4'd1; e_dir = 1'b1;
    miss("miss_right", 1'b0, 1'b1);
    point_expire("p1", SERVE, WINNER_NONE);
    go_play("g2");

    vsync = 1'b1; tick(); vsync = 1'b0;
    e_st = POINT; e_s2 = 4'd1; e_dir = 1'b0;
    miss("miss_left_on_tick", 1'b1, 1'b0);
    point_expire("p2", SERVE, WINNER_NONE);
    go_play("g3");

    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    push("play_start_ignored", 0);
    e_st = POINT;
    miss("miss_both", 1'b1, 1'b1);
    point_expire("p3", SERVE, WINNER_NONE);
    go_play("g4");

    e_st = POINT; e_s1 = 4'd2; e_dir = 1'b1;
    miss("miss_right_win", 1'b0, 1'b1);
    point_expire("p4", OVER, WINNER_P1);
    miss_left = 1'b1; tick(); miss_left = 1'b0; tick();
    push("over_miss_ignored", 0);

    start = 1'b1; tick(); start = 1'b0;
    push("over_start_rise", 0);
    e_st = SERVE; e_s1 = 4'd0; e_s2 = 4'd0; e_win = WINNER_NONE; e_dir = 1'b1;
    push("restart", 1);
    tick(); tick();

    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    e_st = IDLE;
    push("mid_reset", 0);

    repeat (4) tick();
    while (q.size() != 0) begin
      m_e = q.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never checked", m_e.name, m_e.at);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match sequencer for the pong datapath: owns the game state machine, scores, serve direction and inter-point delays.
- Drives the pong renderer's ball motion enables.
- Consumes the ball-miss events the renderer reports.
- Sits beside the hvsync generator and the paddle blocks in the top level. All timing is counted in frames derived from vsync.

Parameters:
- WIN_SCORE, 11, points needed to win; must be < 2**SCORE_W.
- SCORE_W, 4, width of each score counter.
- SERVE_FRAMES, 60, frames the ball is held centred before launch.
- POINT_FRAMES, 90, frames of freeze after a point is scored.
- TIMER_W, 8, frame-timer width; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high; wired as !rst_n at the top.
- vsync  in  1  vsync from the hvsync generator; a frame boundary is its rising edge.
- start  in  1  raw start button (ui_in[4]); its rising edge is the event.
- miss_left  in  1  ball passed the left edge this cycle; player 2 scores.
- miss_right  in  1  ball passed the right edge this cycle; player 1 scores.
- frame_tick  out  1  one-cycle pulse per frame boundary.
- ball_run  out  1  ball position advances on frame boundaries.
- ball_center  out  1  renderer forces the ball to screen centre.
- serve_dir  out  1  launch direction: 0 = toward left, 1 = toward right.
- score1  out  SCORE_W  player 1 score.
- score2  out  SCORE_W  player 2 score.
- winner  out  2  00 = none, 01 = player 1, 10 = player 2.
- state  out  3  current FSM state, for debug.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
  - On reset: state IDLE; score1 = score2 = 0; winner = 00; serve_dir = 1; timer = 0.
  - On reset: ball_run = 0, ball_center = 1, frame_tick = 0.
  - Reset asserted mid-game takes effect on the next edge and aborts any timer.
- Edge detection: vsync and start are each registered once.
  - frame_tick = vsync & ~vsync_q, registered, so it appears one cycle after the vsync rise.
  - start_rise is formed the same way.
- Frame timer:
  - Loaded with N on entry to a timed state.
  - Decrements on each frame_tick while nonzero.
  - "expired" means timer == 0, so the state is left exactly N frame_ticks after entry. N = 0 leaves on the next cycle.
- IDLE: ball_center = 1, ball_run = 0; scores hold their last values.
  - start_rise -> clear scores and winner, serve_dir = 1, load SERVE_FRAMES, go to SERVE.
- SERVE: ball_center = 1, ball_run = 0.
  - On expiry (plus the start_rise condition below when PONG_AUTO_SERVE_EN is undefined) -> PLAY.
- PLAY: ball_run = 1, ball_center = 0.
  - miss_left: score2 += 1, serve_dir = 0 (serve toward the conceding player), load POINT_FRAMES, go to POINT.
  - miss_right: score1 += 1, serve_dir = 1, load POINT_FRAMES, go to POINT.
  - Both misses in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - A miss in the same cycle as frame_tick is still taken.
- POINT: ball_run = 0, ball_center = 0 (ball frozen in place).
  - On expiry: if score1 == WIN_SCORE, winner = 01 and go to OVER.
  - Else if score2 == WIN_SCORE, winner = 10 and go to OVER.
  - Else load SERVE_FRAMES and go to SERVE.
- OVER: ball_run = 0, ball_center = 1; scores and winner hold.
  - start_rise -> same actions as start_rise in IDLE.
- Ignored events:
  - miss_left and miss_right are ignored outside PLAY.
  - start_rise is ignored in SERVE (when auto-serve is on), PLAY and POINT.
- Score arithmetic: SCORE_W-bit increment that saturates at 2**SCORE_W - 1 and never wraps.
- All outputs are registered (Moore).

Optional Feature:
- Macro PONG_AUTO_SERVE_EN.
- Defined: SERVE -> PLAY on timer expiry alone.
- Undefined: SERVE -> PLAY requires timer expired AND start_rise.
  - A start_rise before expiry is discarded, not latched.
  - SERVE waits indefinitely with the ball centred.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;
  - DIR_LEFT / DIR_RIGHT constants;
  - WINNER_NONE / P1 / P2 constants;
  - default WIN_SCORE.
- One natural sub-module, rise_detect: one register plus AND-NOT, registered pulse output. It is instantiated for vsync and for start.

Test Plan:
Bench parameters for all scenarios: WIN_SCORE = 2, SERVE_FRAMES = 2, POINT_FRAMES = 1.
- Reset: hold reset for 3 cycles -> state = 0, scores 0/0, winner = 00, ball_center = 1, ball_run = 0, serve_dir = 1.
- Serve timing (auto-serve on):
  - Stimulus: start pulse, then vsync pulses.
  - SERVE is entered 2 cycles after the start rise.
  - ball_run rises on the cycle after the 2nd frame_tick.
  - frame_tick lags each vsync rise by 1 cycle.
- Scoring: in PLAY, pulse miss_right -> score1 = 1, serve_dir = 1, state POINT; after 1 frame_tick -> SERVE. Then miss_left -> score2 = 1, serve_dir = 0.
- Simultaneous misses and stray starts:
  - miss_left and miss_right in the same cycle -> scores unchanged, POINT entered.
  - A miss pulse during SERVE -> ignored.
  - start during PLAY -> ignored.
- Win: score1 reaches 2 -> after the POINT expiry, state OVER and winner = 01. A start rise then -> scores 0/0, winner = 00, SERVE.
- Manual serve (macro undefined): timer expires with no start -> stays in SERVE for 10 frames. A start rise then -> PLAY on the next cycle. A start pulse before expiry -> no effect.
